// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: event encoding and the
// width helpers that the scanner and its event FIFO agree on.
package keypad_pkg;

  // Event word is {release, key index}; release sits directly above the index.
  typedef enum logic {
    EVT_PRESS   = 1'b0,
    EVT_RELEASE = 1'b1
  } evt_kind_e;

  function automatic int key_w(input int num_keys);
    return (num_keys > 1) ? $clog2(num_keys) : 1;
  endfunction

  function automatic int evt_w(input int num_keys);
    return key_w(num_keys) + 1;
  endfunction

  function automatic int release_pos(input int num_keys);
    return key_w(num_keys);
  endfunction

  function automatic int db_cnt_w(input int db_samples);
    return $clog2(db_samples + 1);
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Small synchronous FIFO for key events with full/empty/count status.
// Handshake: the head entry is valid whenever empty=0; pop while empty is ignored,
// push while full is dropped unless a pop happens in the same cycle.
module keypad_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning keypad controller: drives one row per slot, samples the
// columns at slot end, debounces each key and queues press/release events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS   = 4,
  parameter int NUM_COLS   = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DB_SAMPLES = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                 HCLK,
  input  logic                                 HRESETn,
  input  logic                                 scan_en,
  input  logic [NUM_COLS-1:0]                  col,
  output logic [NUM_ROWS-1:0]                  row,
  output logic [NUM_ROWS*NUM_COLS-1:0]         key_state,
  output logic                                 evt_valid,
  output logic [key_w(NUM_ROWS*NUM_COLS):0]    evt_data,
  input  logic                                 evt_pop,
  output logic                                 irq,
  output logic                                 ovf,
  input  logic                                 ovf_clr
);

  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int KEY_W    = key_w(NUM_KEYS);
  localparam int EVT_W    = evt_w(NUM_KEYS);
  localparam int REL_POS  = release_pos(NUM_KEYS);
  localparam int SLOT_W   = $clog2(SCAN_DIV);
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int CNT_W    = db_cnt_w(DB_SAMPLES);
  localparam int FCNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_COLS-1:0] col_meta;
  logic [NUM_COLS-1:0] col_sync;
  logic [NUM_COLS-1:0] sample_reg;
  logic [ROW_W-1:0]    sample_row;
  logic                sample_valid;
  logic [ROW_W-1:0]    row_idx;
  logic [SLOT_W-1:0]   slot_cnt;
  logic                slot_last;
  logic                row_last;
  logic [CNT_W-1:0]    db_cnt [NUM_KEYS];
  logic                eval_en;
  logic [COL_W-1:0]    eval_col;
  logic [KEY_W-1:0]    eval_key;
  logic                raw;
  logic                flip;
  logic                push;
  logic [EVT_W-1:0]    push_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FCNT_W-1:0]   fifo_count;
  logic                overflow;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      col_meta <= '0;
      col_sync <= '0;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  assign slot_last = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign row_last  = (row_idx == ROW_W'(NUM_ROWS - 1));

  // Disabling the scan parks the sequencer at row 0 / slot 0 and drops the
  // pending sample, so the first slot after re-enable never evaluates.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      slot_cnt     <= '0;
      row_idx      <= '0;
      sample_reg   <= '0;
      sample_row   <= '0;
      sample_valid <= 1'b0;
    end else if (!scan_en) begin
      slot_cnt     <= '0;
      row_idx      <= '0;
      sample_valid <= 1'b0;
    end else if (slot_last) begin
      slot_cnt     <= '0;
      row_idx      <= row_last ? '0 : row_idx + ROW_W'(1);
      sample_reg   <= col_sync;
      sample_row   <= row_idx;
      sample_valid <= 1'b1;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  always_comb begin
    row = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      row[r] = HRESETn && scan_en && (row_idx == ROW_W'(r));
    end
  end

  // Slot cycle c of the slot after a capture evaluates column c of the captured row.
  always_comb begin
    eval_col  = slot_cnt[COL_W-1:0];
    eval_en   = scan_en && sample_valid && (int'(slot_cnt) < NUM_COLS);
    eval_key  = KEY_W'(int'(sample_row) * NUM_COLS + int'(eval_col));
    raw       = sample_reg[eval_col];
    flip      = eval_en && (raw != key_state[eval_key]) &&
                (db_cnt[eval_key] == CNT_W'(DB_SAMPLES - 1));
    push      = flip;
    push_data = '0;
    push_data[KEY_W-1:0] = eval_key;
    push_data[REL_POS]   = raw ? EVT_PRESS : EVT_RELEASE;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      key_state <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        db_cnt[k] <= '0;
      end
    end else if (eval_en) begin
      if (raw == key_state[eval_key]) begin
        db_cnt[eval_key] <= '0;
      end else if (flip) begin
        key_state[eval_key] <= raw;
        db_cnt[eval_key]    <= '0;
      end else begin
        db_cnt[eval_key] <= db_cnt[eval_key] + CNT_W'(1);
      end
    end
  end

  keypad_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_evt_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (push),
    .push_data (push_data),
    .pop       (evt_pop),
    .pop_data  (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign evt_valid = !fifo_empty;
  assign irq       = (fifo_count != '0);

  // A full FIFO only loses the new event when nothing leaves in the same cycle.
  assign overflow = push && fifo_full && !evt_pop;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ovf <= 1'b0;
    end else if (overflow) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 4, number of driven matrix rows (2..8).
REQ-002 SHALL have parameter NUM_COLS, default 4, number of sensed matrix columns (2..8).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, HCLK cycles per row slot (>= max(NUM_COLS,4)).
REQ-004 SHALL have parameter DB_SAMPLES, default 4, consecutive differing samples needed to flip a key (1..15).
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, >= 2).
REQ-006 SHALL have ports HCLK in 1 (system clock) and HRESETn in 1 (reset); one clock; reset is synchronous and active-low.
REQ-007 SHALL have scan_en in 1 (scan enable), col in NUM_COLS (asynchronous column inputs, 1 = pressed), row out NUM_ROWS (one-hot row drive, active-high).
REQ-008 SHALL have key_state out NUM_KEYS (debounced level per key), where NUM_KEYS = NUM_ROWS*NUM_COLS and key index = r*NUM_COLS + c.
REQ-009 SHALL have evt_valid out 1, evt_data out KEY_W+1 ({release, key index}, KEY_W = clog2(NUM_KEYS)), evt_pop in 1.
REQ-010 SHALL have irq out 1 (FIFO non-empty), ovf out 1 (sticky overflow), ovf_clr in 1.

Function
REQ-011 SHALL pass col through a 2-flop synchronizer before any use.
REQ-012 SHALL run a slot counter 0..SCAN_DIV-1 and row index 0..NUM_ROWS-1, row index advancing (wrapping NUM_ROWS-1 -> 0) when slot counter wraps.
REQ-013 SHALL drive row[r]=1 only while row index = r and scan_en=1; all zeros otherwise.
REQ-014 SHALL capture synchronized col into a sample register at slot cycle SCAN_DIV-1, tagged with the current row index.
REQ-015 SHALL evaluate key (tagged row, c) at slot cycle c of the following slot, one key per cycle.
REQ-016 SHALL per key: raw == key_state -> count cleared; raw != key_state -> count+1; count reaching DB_SAMPLES -> key_state toggles, count cleared, event generated.
REQ-017 SHALL encode event as release=1 for 1->0, release=0 for 0->1, with the key index.
REQ-018 SHALL push at most one event per cycle; pushed event visible at FIFO head no earlier than the next cycle.
REQ-019 SHALL present head entry on evt_data with evt_valid=1 whenever FIFO non-empty; evt_pop with evt_valid=1 removes head; evt_pop while empty ignored.
REQ-020 SHALL on push to full FIFO without same-cycle pop drop the new event and set ovf; push and pop together at full both succeed, no ovf.
REQ-021 SHALL clear ovf on ovf_clr; a same-cycle overflow wins (ovf stays 1).
REQ-022 SHALL assert irq = evt_valid (level, combinational from FIFO count).
REQ-023 SHALL on scan_en=0 hold slot counter, row index and pending evaluation at reset values, keep key_state, counts and FIFO contents unchanged.
REQ-024 SHALL on scan_en 0->1 restart at row 0, slot cycle 0, with no evaluation in the first slot.

Reset
REQ-025 SHALL on HRESETn=0 at a rising HCLK edge clear: synchronizer, sample register, slot counter, row index, all debounce counts, key_state, FIFO pointers/count, ovf.
REQ-026 SHALL hold row=0, evt_valid=0, irq=0, ovf=0, key_state=0 during and immediately after reset; reset mid-scan discards pending evaluations and queued events.

Structure
REQ-027 SHALL place event-field widths, KEY_W derivation and release-bit position in shared package keypad_pkg.
REQ-028 SHALL implement the event FIFO as sub-module keypad_evt_fifo (parametrised depth/width, push/pop/full/empty/count).
REQ-029 SHALL keep debounce counters as a flat per-key array, width clog2(DB_SAMPLES+1).

Verification (NUM_ROWS=4, NUM_COLS=4, SCAN_DIV=8, DB_SAMPLES=3, FIFO_DEPTH=4; scan period 32 cycles)
REQ-030 SHALL cover press: col[1]=1 only while row[1]=1, held 4 scan periods -> exactly one event {0,5}, key_state[5]=1, irq=1 until popped.
REQ-031 SHALL cover bounce: key 5 pressed for 2 consecutive row-1 samples then released -> no event, key_state[5] stays 0.
REQ-032 SHALL cover release: after REQ-030, col[1]=0 for 3 samples -> event {1,5}, key_state[5]=0.
REQ-033 SHALL cover overflow: 5 events with no pops -> FIFO holds first 4, ovf=1; ovf_clr -> ovf=0; push+pop at full -> count stays 4, ovf=0.
REQ-034 SHALL cover reset mid-operation: HRESETn=0 one cycle with 3 queued events and key_state[5]=1 -> next cycle evt_valid=0, key_state=0, row=0001 once scanning.
REQ-035 SHALL cover scan_en=0 for 100 cycles -> row=0000, key_state and FIFO unchanged; re-enable -> row=0001 at first enabled cycle.
